// File: rtl/instr_cache_fill_ctrl.sv
// Instruction-cache refill engine: fetches one B-byte block word by word and presents it to the sets.
// Optional build macro INSTR_FILL_CRITICAL_WORD_FIRST_EN starts the fetch at the missing word.
module instr_cache_fill_ctrl #(
  parameter int B      = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CacheMiss,
  input  logic [ADDR_W-1:0] MissAddr,
  input  logic              Flush,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemAck,
  input  logic [31:0]       MemRData,
  output logic              RepReady,
  output logic [B*8-1:0]    RepBlock,
  output logic              FillBusy,
  output logic [1:0]        dbg_state
);

  localparam int WORDS = B / 4;
  localparam int IDX_W = $clog2(WORDS);
  localparam int OFF_W = $clog2(B);
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   blk_q, blk_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   start_idx;
  logic               req_d, rdy_d, busy_d, wr_en;
  logic [ADDR_W-1:0]  addr_d;
  logic               unused_low_bits;

`ifdef INSTR_FILL_CRITICAL_WORD_FIRST_EN
  assign start_idx = MissAddr[OFF_W-1:2];
`else
  assign start_idx = '0;
`endif

  assign unused_low_bits = ^MissAddr[OFF_W-1:0];
  assign dbg_state       = state_q;

  // Memory handshake: MemReq/MemAddr stay stable until a cycle with MemAck=1; that
  // edge consumes MemRData. MemAck with MemReq=0 or together with Flush is ignored.
  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    req_d   = MemReq;
    addr_d  = MemAddr;
    rdy_d   = RepReady;
    wr_en   = 1'b0;
    if (Flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      req_d   = 1'b0;
      addr_d  = '0;
      rdy_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (CacheMiss) begin
            state_d = FETCH;
            blk_d   = MissAddr[ADDR_W-1:OFF_W];
            idx_d   = start_idx;
            cnt_d   = '0;
          end
        end
        FETCH: begin
          // First FETCH cycle only raises the request; later cycles wait for acks.
          if (!MemReq) begin
            req_d  = 1'b1;
            addr_d = {blk_q, idx_q, 2'b00};
          end else if (MemAck) begin
            wr_en = 1'b1;
            idx_d = idx_q + 1'b1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              state_d = DONE;
              req_d   = 1'b0;
              addr_d  = '0;
              rdy_d   = 1'b1;
            end else begin
              addr_d = {blk_q, idx_d, 2'b00};
            end
          end
        end
        DONE: begin
          if (!CacheMiss) begin
            state_d = IDLE;
            rdy_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          req_d   = 1'b0;
          rdy_d   = 1'b0;
        end
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      blk_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      MemReq   <= 1'b0;
      MemAddr  <= '0;
      RepReady <= 1'b0;
      RepBlock <= '0;
      FillBusy <= 1'b0;
    end else begin
      state_q  <= state_d;
      blk_q    <= blk_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      MemReq   <= req_d;
      MemAddr  <= addr_d;
      RepReady <= rdy_d;
      FillBusy <= busy_d;
      if (wr_en) RepBlock[32*idx_q +: 32] <= MemRData;
    end
  end

endmodule

// File: tb/tb_instr_cache_fill_ctrl.sv
// Bench for instr_cache_fill_ctrl: directed fills, a memory responder, and a scoreboard
// monitor checking every consumed request address and every completed block.
module tb_instr_cache_fill_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         CacheMiss;
  logic [31:0]  MissAddr;
  logic         Flush;
  logic         MemReq;
  logic [31:0]  MemAddr;
  logic         MemAck;
  logic [31:0]  MemRData;
  logic         RepReady;
  logic [511:0] RepBlock;
  logic         FillBusy;
  logic [1:0]   dbg_state;

  instr_cache_fill_ctrl #(.B(64), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .CacheMiss(CacheMiss), .MissAddr(MissAddr), .Flush(Flush),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck), .MemRData(MemRData),
    .RepReady(RepReady), .RepBlock(RepBlock), .FillBusy(FillBusy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0]  exp_q[$];
  logic [511:0] exp_blk_q[$];
  logic [511:0] last_blk = '0;

  int          ack_period = 1;
  int          stall_cnt  = 0;
  int          ack_n      = 0;
  int          flush_at   = -1;
  logic [31:0] data_tag   = '0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected request order and block image for one fill, from the address and data tag.
  task automatic push_fill(input logic [31:0] addr, input logic [31:0] tag,
                           input int nwords, input bit with_blk);
    logic [3:0]   start;
    logic [3:0]   w;
    logic [511:0] blk;
`ifdef INSTR_FILL_CRITICAL_WORD_FIRST_EN
    start = addr[5:2];
`else
    start = 4'd0;
`endif
    blk = '0;
    for (int k = 0; k < 16; k++) begin
      w = start + 4'(k);
      blk[32*w +: 32] = tag + 32'(k);
      if (k < nwords) exp_q.push_back({addr[31:6], w, 2'b00});
    end
    if (with_blk) begin
      exp_blk_q.push_back(blk);
      last_blk = blk;
    end
  endtask

  task automatic start_fill(input logic [31:0] addr, input logic [31:0] tag, input int period);
    ack_period = period;
    stall_cnt  = 0;
    ack_n      = 0;
    data_tag   = tag;
    MissAddr   = addr;
    CacheMiss  = 1'b1;
  endtask

  task automatic wait_ready(input int budget, output int edges);
    edges = 0;
    while (edges < budget) begin
      @(posedge clk); #1;
      edges++;
      if (RepReady) break;
    end
    if (!RepReady) begin
      tests++;
      fails++;
      $display("FAIL wait_ready: RepReady not seen within %0d cycles", budget);
      edges = -1;
    end
  endtask

  // Memory responder: acks every ack_period-th requesting cycle; data is tag + ack number.
  initial begin
    MemAck   = 1'b0;
    MemRData = '0;
    Flush    = 1'b0;
    forever begin
      @(posedge clk); #1;
      MemAck = 1'b0;
      Flush  = 1'b0;
      if (reset && MemReq) begin
        stall_cnt++;
        if (stall_cnt >= ack_period) begin
          stall_cnt = 0;
          MemAck    = 1'b1;
          MemRData  = data_tag + 32'(ack_n);
          if (ack_n == flush_at) begin
            Flush    = 1'b1;
            flush_at = -1;
          end
          ack_n++;
        end
      end
    end
  end

  // Scoreboard monitor.
  logic        prev_req  = 1'b0;
  logic        prev_ack  = 1'b0;
  logic        prev_rdy  = 1'b0;
  logic [31:0] prev_addr = '0;
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_req = 1'b0;
        prev_ack = 1'b0;
        prev_rdy = 1'b0;
      end else begin
        if (prev_req && !prev_ack && MemReq) check("addr_hold", MemAddr, prev_addr);
        if (MemReq && MemAck && !Flush) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_req: got addr %0h expected none", MemAddr);
          end else begin
            check("mem_addr", MemAddr, exp_q.pop_front());
          end
        end
        if (RepReady && !prev_rdy) begin
          if (exp_blk_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_block: got %0h expected none", RepBlock);
          end else begin
            check("rep_block", RepBlock, exp_blk_q.pop_front());
          end
        end
        prev_req  = MemReq;
        prev_ack  = MemAck;
        prev_addr = MemAddr;
        prev_rdy  = RepReady;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  int  e;
  bit  seen;
  logic [31:0] first_addr;

  initial begin
    reset     = 1'b0;
    CacheMiss = 1'b0;
    MissAddr  = '0;
    #12;
    check("rst_memreq",  MemReq,    0);
    check("rst_memaddr", MemAddr,   0);
    check("rst_repready", RepReady, 0);
    check("rst_block",   RepBlock,  0);
    check("rst_busy",    FillBusy,  0);
    check("rst_state",   dbg_state, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Base fill, then hold and release.
    start_fill(32'h0000_1234, 32'hA000_0000, 1);
    push_fill(32'h0000_1234, 32'hA000_0000, 16, 1'b1);
    @(posedge clk); #1;
    check("t1_edge0_req",  MemReq,   0);
    check("t1_edge0_busy", FillBusy, 1);
    @(posedge clk); #1;
`ifdef INSTR_FILL_CRITICAL_WORD_FIRST_EN
    first_addr = 32'h0000_1234;
`else
    first_addr = 32'h0000_1200;
`endif
    check("t1_edge1_req",  MemReq,  1);
    check("t1_first_addr", MemAddr, first_addr);
    MissAddr = 32'hFFFF_FFFF;
    wait_ready(40, e);
    check("t1_latency", 32'(e + 1), 17);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("t3_hold_rdy", RepReady, 1);
      check("t3_hold_blk", RepBlock, last_blk);
    end
    CacheMiss = 1'b0;
    @(posedge clk); #1;
    check("t3_rel_rdy",  RepReady, 0);
    check("t3_rel_busy", FillBusy, 0);
    check("t3_keep_blk", RepBlock, last_blk);

    // Memory stall: ack every third requesting cycle.
    @(posedge clk); #1;
    start_fill(32'h0000_5678, 32'hB000_0000, 3);
    push_fill(32'h0000_5678, 32'hB000_0000, 16, 1'b1);
    wait_ready(200, e);
    check("t2_acks", 32'(ack_n), 16);
    CacheMiss = 1'b0;
    @(posedge clk); #1;
    check("t2_rel_rdy", RepReady, 0);

    // Flush together with the word-7 ack, then a fresh fill at 0x2000.
    @(posedge clk); #1;
    flush_at = 7;
    start_fill(32'h0000_3000, 32'hC000_0000, 1);
    push_fill(32'h0000_3000, 32'hC000_0000, 7, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (Flush) seen = 1'b1;
    end
    CacheMiss = 1'b0;
    check("t4_flush_seen", seen, 1);
    @(posedge clk); #1;
    check("t4_req",   MemReq,    0);
    check("t4_busy",  FillBusy,  0);
    check("t4_state", dbg_state, 0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t4_no_rdy", RepReady, 0);
    end
    start_fill(32'h0000_2000, 32'hD000_0000, 1);
    push_fill(32'h0000_2000, 32'hD000_0000, 16, 1'b1);
    wait_ready(40, e);
    check("t4_latency", 32'(e), 18);
    CacheMiss = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset while word 5 is being acked.
    start_fill(32'h0000_4000, 32'hE000_0000, 1);
    push_fill(32'h0000_4000, 32'hE000_0000, 6, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ack_n >= 6) seen = 1'b1;
    end
    check("t5_reached_word5", seen, 1);
    #2;
    reset     = 1'b0;
    CacheMiss = 1'b0;
    #1;
    check("t5_req",   MemReq,    0);
    check("t5_rdy",   RepReady,  0);
    check("t5_block", RepBlock,  0);
    check("t5_busy",  FillBusy,  0);
    check("t5_state", dbg_state, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("t5_idle_req",  MemReq,   0);
    check("t5_idle_busy", FillBusy, 0);

    check("queue_drain", 32'(exp_q.size() + exp_blk_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
